// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, condition codes, flag bit positions and
// the writeback-stage state type.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_LDR  = 4'b1101;
    localparam logic [3:0] OP_STR  = 4'b1110;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } wb_state_t;

    // ALU-type opcodes occupy the whole lower half of the opcode space.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against an NZCV flag word.
// Shared with any unit that needs predicated execution (e.g. branches).
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags_Q,
    output logic       Pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = Flags_Q[FLAG_N];
    assign w_z = Flags_Q[FLAG_Z];
    assign w_c = Flags_Q[FLAG_C];
    assign w_v = Flags_Q[FLAG_V];

    always_comb begin
        Pass = 1'b0;
        case (Cond)
            CC_EQ:   Pass = w_z;
            CC_NE:   Pass = !w_z;
            CC_CS:   Pass = w_c;
            CC_CC:   Pass = !w_c;
            CC_MI:   Pass = w_n;
            CC_PL:   Pass = !w_n;
            CC_VS:   Pass = w_v;
            CC_VC:   Pass = !w_v;
            CC_HI:   Pass = w_c && !w_z;
            CC_LS:   Pass = !w_c || w_z;
            CC_GE:   Pass = (w_n == w_v);
            CC_LT:   Pass = (w_n != w_v);
            CC_GT:   Pass = !w_z && (w_n == w_v);
            CC_LE:   Pass = w_z || (w_n != w_v);
            CC_AL:   Pass = 1'b1;
            default: Pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: predicates ALU results on the owned NZCV
// register, writes the register file and runs LDR/STR memory transactions.
module alu_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [DW-1:0] Out,
    input  logic [3:0]    Flags,
    input  logic [3:0]    Opcode,
    input  logic [3:0]    Cond,
    input  logic          S,
    input  logic [RW-1:0] Rd,
    input  logic [DW-1:0] Store_Data,
    output logic          Mem_Req,
    output logic          Mem_We,
    output logic [DW-1:0] Mem_Addr,
    output logic [DW-1:0] Mem_WData,
    input  logic          Mem_Ack,
    input  logic [DW-1:0] Mem_RData,
    output logic          Wb_En,
    output logic [RW-1:0] Wb_Addr,
    output logic [DW-1:0] Wb_Data,
    output logic [3:0]    Flags_Q
);

    wb_state_t     r_state;
    logic          r_in_ready;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_wb_en;
    logic [RW-1:0] r_wb_addr;
    logic [DW-1:0] r_wb_data;
    logic [3:0]    r_flags;

    logic          w_pass;
    logic          w_is_alu;
    logic          w_is_mem;

    // Condition is judged against the flags as they stand at the accept edge.
    cond_check u_cond_check (
        .Cond    (Cond),
        .Flags_Q (r_flags),
        .Pass    (w_pass)
    );

    assign w_is_alu = is_alu_op(Opcode);
    assign w_is_mem = is_mem_op(Opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_flags     <= 4'b0000;
        end else begin
            r_wb_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Failed conditions and NOPs are consumed without leaving IDLE.
                    if (In_Valid && w_pass) begin
                        if (w_is_alu) begin
                            r_wb_en    <= 1'b1;
                            r_wb_addr  <= Rd;
                            r_wb_data  <= Out;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_WB;
                            if (S) begin
                                r_flags <= Flags;
                            end
                        end else if (w_is_mem) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= (Opcode == OP_STR);
                            r_mem_addr  <= Out;
                            r_mem_wdata <= Store_Data;
                            r_wb_addr   <= Rd;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_MEM;
                        end
                    end
                end
                ST_MEM: begin
                    if (Mem_Ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_mem_we) begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_wb_en   <= 1'b1;
                            r_wb_data <= Mem_RData;
                            r_state   <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_mem_req  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign In_Ready  = r_in_ready;
    assign Mem_Req   = r_mem_req;
    assign Mem_We    = r_mem_we;
    assign Mem_Addr  = r_mem_addr;
    assign Mem_WData = r_mem_wdata;
    assign Wb_En     = r_wb_en;
    assign Wb_Addr   = r_wb_addr;
    assign Wb_Data   = r_wb_data;
    assign Flags_Q   = r_flags;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed scenarios, randomized traffic
// against a behavioural model, and a reset-during-transaction scenario.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Out;
    logic [3:0]  Flags;
    logic [3:0]  Opcode;
    logic [3:0]  Cond;
    logic        S;
    logic [3:0]  Rd;
    logic [31:0] Store_Data;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic        Wb_En;
    logic [3:0]  Wb_Addr;
    logic [31:0] Wb_Data;
    logic [3:0]  Flags_Q;

    alu_wb_stage #(.DW(32), .RW(4)) dut (
        .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out(Out), .Flags(Flags), .Opcode(Opcode), .Cond(Cond), .S(S),
        .Rd(Rd), .Store_Data(Store_Data), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_Ack(Mem_Ack),
        .Mem_RData(Mem_RData), .Wb_En(Wb_En), .Wb_Addr(Wb_Addr),
        .Wb_Data(Wb_Data), .Flags_Q(Flags_Q)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] a; logic [31:0] d; } wb_t;
    typedef struct { logic we; logic [31:0] a; logic [31:0] d; } mem_t;

    wb_t  wbq[$];
    mem_t memq[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  mflags;
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] resp_mem  [logic [31:0]];
    int          resp_delay = 0;
    bit          resp_en = 1'b0;
    bit          force_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a * 32'h9E37_79B1;
    endfunction

    // Odd condition codes are the negation of the even code below them.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Issue one instruction, update the model and push expected responses.
    task automatic issue(input logic [3:0] op, input logic [3:0] cc, input logic s,
                         input logic [3:0] fl, input logic [3:0] rd,
                         input logic [31:0] out, input logic [31:0] sd, input int dly);
        int n;
        bit pass, alu, mem;
        logic [31:0] ld;
        n = 0;
        @(negedge clk);
        while (In_Ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (In_Ready !== 1'b1) chk("ready_timeout", {31'b0, In_Ready}, 32'd1);
        Opcode = op; Cond = cc; S = s; Flags = fl; Rd = rd; Out = out;
        Store_Data = sd; resp_delay = dly; In_Valid = 1'b1;
        pass = cond_ok(cc, mflags);
        alu  = (op <= 4'd7);
        mem  = (op == 4'd13) || (op == 4'd14);
        if (pass && alu) begin
            wbq.push_back('{a: rd, d: out});
            if (s) mflags = fl;
        end
        if (pass && mem) begin
            memq.push_back('{we: (op == 4'd14), a: out, d: sd});
            if (op == 4'd13) begin
                ld = model_mem.exists(out) ? model_mem[out] : mem_default(out);
                wbq.push_back('{a: rd, d: ld});
            end else begin
                model_mem[out] = sd;
            end
        end
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
        chk("flags_after_accept", {28'b0, Flags_Q}, {28'b0, mflags});
        chk("ready_after_accept", {31'b0, In_Ready}, {31'b0, !(pass && (alu || mem))});
        if (pass && mem) begin
            n = 0;
            while (Mem_Req === 1'b1 && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("mem_req_cycles", n, dly + 1);
        end
    endtask

    // Memory responder: acks after resp_delay extra cycles, stray acks when idle.
    initial begin : responder
        int  cnt;
        bit  seen;
        cnt = 0; seen = 1'b0;
        Mem_Ack = 1'b0; Mem_RData = '0;
        forever begin
            @(negedge clk);
            Mem_Ack = 1'b0;
            if (force_ack) begin
                Mem_Ack = 1'b1;
                Mem_RData = 32'h1234_5678;
            end else if (resp_en && Mem_Req === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    cnt = resp_delay;
                end
                if (cnt == 0) begin
                    Mem_Ack = 1'b1;
                    Mem_RData = resp_mem.exists(Mem_Addr) ? resp_mem[Mem_Addr] : mem_default(Mem_Addr);
                    if (Mem_We) resp_mem[Mem_Addr] = Mem_WData;
                    seen = 1'b0;
                end else begin
                    cnt--;
                    Mem_RData = $urandom;
                end
            end else begin
                seen = 1'b0;
                if (resp_en && $urandom_range(0, 7) == 0) begin
                    Mem_Ack = 1'b1;
                    Mem_RData = $urandom;
                end
            end
        end
    end

    initial begin : wb_monitor
        wb_t e;
        forever begin
            @(negedge clk);
            if (Wb_En === 1'b1) begin
                if (wbq.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wbq.pop_front();
                    chk("wb_addr", {28'b0, Wb_Addr}, {28'b0, e.a});
                    chk("wb_data", Wb_Data, e.d);
                end
            end
        end
    end

    initial begin : mem_monitor
        mem_t cur;
        bit   prev;
        prev = 1'b0;
        cur = '{we: 1'b0, a: '0, d: '0};
        forever begin
            @(negedge clk);
            if (Mem_Req === 1'b1) begin
                if (!prev) begin
                    if (memq.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
                    else cur = memq.pop_front();
                end
                chk("mem_addr", Mem_Addr, cur.a);
                chk("mem_we", {31'b0, Mem_We}, {31'b0, cur.we});
                if (cur.we) chk("mem_wdata", Mem_WData, cur.d);
            end
            prev = (Mem_Req === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [3:0]  op, cc;
        rst = 1'b1; In_Valid = 1'b0; Out = '0; Flags = '0; Opcode = '0;
        Cond = '0; S = 1'b0; Rd = '0; Store_Data = '0;
        mflags = 4'b0000;
        model_mem[32'h40] = 32'hDEAD_BEEF;
        resp_mem[32'h40]  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_flags", {28'b0, Flags_Q}, 32'd0);
        chk("rst_ready", {31'b0, In_Ready}, 32'd1);
        chk("rst_mem_req", {31'b0, Mem_Req}, 32'd0);
        chk("rst_wb_en", {31'b0, Wb_En}, 32'd0);
        chk("rst_mem_we", {31'b0, Mem_We}, 32'd0);
        chk("rst_mem_addr", Mem_Addr, 32'd0);
        chk("rst_wb_data", Wb_Data, 32'd0);
        resp_en = 1'b1;

        issue(4'd0, 4'b1110, 1'b1, 4'b0000, 4'd3, 32'd35, 32'd0, 0);
        issue(4'd1, 4'b1110, 1'b1, 4'b0100, 4'd4, 32'd7, 32'd0, 0);
        chk("flags_after_sub", {28'b0, Flags_Q}, 32'h4);
        issue(4'd7, 4'b0001, 1'b1, 4'b1111, 4'd6, 32'd99, 32'd0, 0);
        issue(4'd7, 4'b0000, 1'b0, 4'b1111, 4'd6, 32'd99, 32'd0, 0);
        issue(4'd13, 4'b1110, 1'b1, 4'b1111, 4'd5, 32'h40, 32'd0, 2);
        chk("flags_after_ldr", {28'b0, Flags_Q}, 32'h4);
        issue(4'd14, 4'b1110, 1'b0, 4'b0000, 4'd2, 32'h80, 32'd30, 1);
        issue(4'd13, 4'b1110, 1'b0, 4'b0000, 4'd9, 32'h80, 32'd0, 0);
        issue(4'd9, 4'b1110, 1'b1, 4'b1111, 4'd1, 32'd5, 32'd0, 0);
        issue(4'd9, 4'b1110, 1'b1, 4'b1111, 4'd1, 32'd6, 32'd0, 0);

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd13 : 4'd14;
            cc = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
            a = (op >= 4'd13) ? (32'($urandom_range(0, 15)) << 2) : $urandom;
            issue(op, cc, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), a, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of an LDR, followed by a late ack.
        repeat (3) @(negedge clk);
        resp_en = 1'b0;
        @(negedge clk);
        Opcode = 4'd13; Cond = 4'b1110; S = 1'b0; Out = 32'h44; Rd = 4'd7;
        In_Valid = (In_Ready === 1'b1);
        memq.push_back('{we: 1'b0, a: 32'h44, d: 32'd0});
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
        chk("rstmid_req_up", {31'b0, Mem_Req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_ack = 1'b1;
        mflags = 4'b0000;
        chk("rstmid_req", {31'b0, Mem_Req}, 32'd0);
        chk("rstmid_wb_en", {31'b0, Wb_En}, 32'd0);
        chk("rstmid_ready", {31'b0, In_Ready}, 32'd1);
        chk("rstmid_flags", {28'b0, Flags_Q}, 32'd0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("late_ack_req", {31'b0, Mem_Req}, 32'd0);
        chk("late_ack_wb_en", {31'b0, Wb_En}, 32'd0);
        chk("late_ack_ready", {31'b0, In_Ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("wbq_drained", wbq.size(), 32'd0);
        chk("memq_drained", memq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
